bus_snapshot_fifo: RTL and testbench

- Captures one record per completed 68000 bus cycle: address, data, and a status byte.
- Buffers records in a small FIFO.
- Presents exactly one record, held stable, for each SPI read window of the downstream SPI monitor shifter.
- Sits between the CPU bus pins and the monitor. Its three outputs drive the monitor's ADDR_IN, DATA_IN and OUTPUT_SIGNAL_IN.

---
 rtl/bus_snapshot_fifo_pkg.sv | 30 +++
 rtl/bus_snapshot_fifo_sync_fifo.sv | 62 ++++++
 rtl/bus_snapshot_fifo.sv | 121 ++++++++++++
 tb/tb_bus_snapshot_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_snapshot_fifo_pkg.sv
// rtl/bus_snapshot_fifo_pkg.sv - shared widths, record layout and SIGNAL_OUT bit positions
package bus_snapshot_fifo_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int FC_W   = 3;
  localparam int SIG_W  = 8;
  localparam int REC_W  = ADDR_W + DATA_W + SIG_W;

  // Captured fields only; VALID and OVERFLOW are added when a record is presented.
  localparam int CAP_W  = ADDR_W + DATA_W + 3 + FC_W;

  localparam int SIG_VALID = 7;
  localparam int SIG_OVR   = 6;
  localparam int SIG_RW    = 5;
  localparam int SIG_UDS   = 4;
  localparam int SIG_LDS   = 3;
  localparam int SIG_FC_HI = 2;
  localparam int SIG_FC_LO = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
    logic              uds_n;
    logic              lds_n;
    logic [FC_W-1:0]   fc;
  } cap_rec_t;

endpackage

// File: rtl/bus_snapshot_fifo_sync_fifo.sv
// rtl/bus_snapshot_fifo_sync_fifo.sv - generic DEPTH x WIDTH FIFO with occupancy count
module sync_fifo
  import bus_snapshot_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CAP_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_snapshot_fifo.sv
// rtl/bus_snapshot_fifo.sv - captures one record per 68000 bus cycle and presents one per SPI window
module bus_snapshot_fifo
  import bus_snapshot_fifo_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       CLK_IN,
  input  logic                       RESET_IN,
  input  logic [ADDR_W-1:0]          ADDR_IN,
  input  logic [DATA_W-1:0]          DATA_IN,
  input  logic                       AS_N_IN,
  input  logic                       DTACK_N_IN,
  input  logic                       RW_IN,
  input  logic                       UDS_N_IN,
  input  logic                       LDS_N_IN,
  input  logic [FC_W-1:0]            FC_IN,
  input  logic                       SPISS_IN,
  output logic [ADDR_W-1:0]          ADDR_OUT,
  output logic [DATA_W-1:0]          DATA_OUT,
  output logic [SIG_W-1:0]           SIGNAL_OUT,
  output logic [$clog2(DEPTH+1)-1:0] COUNT_OUT
);

  logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
  logic [SYNC_STAGES-1:0] dtack_sync_q, dtack_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   ack_q, ack_d;
  logic                   ss_q, ss_d;
  logic                   ovf_q, ovf_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [SIG_W-1:0]       sig_q, sig_d;

  logic     ack;
  logic     ss_s;
  logic     push;
  logic     pop;
  logic     fifo_full;
  logic     fifo_empty;
  cap_rec_t cap_rec;
  cap_rec_t head_rec;

  // Shift in at the LSB; the MSB is the fully synchronised value.
  assign as_sync_d    = (as_sync_q << 1)    | SYNC_STAGES'(AS_N_IN);
  assign dtack_sync_d = (dtack_sync_q << 1) | SYNC_STAGES'(DTACK_N_IN);
  assign ss_sync_d    = (ss_sync_q << 1)    | SYNC_STAGES'(SPISS_IN);

  assign ack   = ~as_sync_q[SYNC_STAGES-1] & ~dtack_sync_q[SYNC_STAGES-1];
  assign ss_s  = ss_sync_q[SYNC_STAGES-1];
  assign ack_d = ack;
  assign ss_d  = ss_s;
  assign push  = ack & ~ack_q;
  assign pop   = ss_s & ~ss_q;

  assign cap_rec = {ADDR_IN, DATA_IN, RW_IN, UDS_N_IN, LDS_N_IN, FC_IN};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CAP_W)
  ) u_fifo (
    .clk_i   (CLK_IN),
    .rst_ni  (RESET_IN),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cap_rec),
    .rdata_o (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (COUNT_OUT)
  );

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    sig_d  = sig_q;
    ovf_d  = ovf_q;
    if (pop) begin
      if (!fifo_empty) begin
        addr_d = head_rec.addr;
        data_d = head_rec.data;
        sig_d  = {1'b1, ovf_q, head_rec.rw, head_rec.uds_n, head_rec.lds_n, head_rec.fc};
        ovf_d  = 1'b0;
      end else begin
        sig_d[SIG_VALID] = 1'b0;
        sig_d[SIG_OVR]   = ovf_q;
      end
    end
    // Only a push into a full FIFO without a pop is dropped; that drop always wins the flag.
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      as_sync_q    <= '1;
      dtack_sync_q <= '1;
      ss_sync_q    <= '0;
      ack_q        <= 1'b0;
      ss_q         <= 1'b0;
      ovf_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      sig_q        <= '0;
    end else begin
      as_sync_q    <= as_sync_d;
      dtack_sync_q <= dtack_sync_d;
      ss_sync_q    <= ss_sync_d;
      ack_q        <= ack_d;
      ss_q         <= ss_d;
      ovf_q        <= ovf_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      sig_q        <= sig_d;
    end
  end

  assign ADDR_OUT   = addr_q;
  assign DATA_OUT   = data_q;
  assign SIGNAL_OUT = sig_q;

endmodule

// File: tb/tb_bus_snapshot_fifo.sv
// tb/tb_bus_snapshot_fifo.sv - randomized and directed bench against a queue-based reference model
module tb_bus_snapshot_fifo;

  localparam int DEPTH = 4;
  localparam int SS    = 2;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [2:0]  fc;
  } rec_t;

  logic        CLK_IN = 1'b0;
  logic        RESET_IN;
  logic [23:0] ADDR_IN;
  logic [15:0] DATA_IN;
  logic        AS_N_IN, DTACK_N_IN, RW_IN, UDS_N_IN, LDS_N_IN;
  logic [2:0]  FC_IN;
  logic        SPISS_IN;
  logic [23:0] ADDR_OUT;
  logic [15:0] DATA_OUT;
  logic [7:0]  SIGNAL_OUT;
  logic [2:0]  COUNT_OUT;

  bus_snapshot_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .CLK_IN     (CLK_IN),
    .RESET_IN   (RESET_IN),
    .ADDR_IN    (ADDR_IN),
    .DATA_IN    (DATA_IN),
    .AS_N_IN    (AS_N_IN),
    .DTACK_N_IN (DTACK_N_IN),
    .RW_IN      (RW_IN),
    .UDS_N_IN   (UDS_N_IN),
    .LDS_N_IN   (LDS_N_IN),
    .FC_IN      (FC_IN),
    .SPISS_IN   (SPISS_IN),
    .ADDR_OUT   (ADDR_OUT),
    .DATA_OUT   (DATA_OUT),
    .SIGNAL_OUT (SIGNAL_OUT),
    .COUNT_OUT  (COUNT_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  int n_checks = 0;
  int n_errors = 0;

  rec_t        m_q[$];
  logic        m_ovf;
  logic [23:0] m_addr;
  logic [15:0] m_data;
  logic [7:0]  m_sig;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_IN);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_sig  = '0;
  endtask

  task automatic model_push(input rec_t r);
    if (m_q.size() < DEPTH) m_q.push_back(r);
    else m_ovf = 1'b1;
  endtask

  task automatic model_pop();
    rec_t r;
    if (m_q.size() > 0) begin
      r      = m_q.pop_front();
      m_addr = r.addr;
      m_data = r.data;
      m_sig  = {1'b1, m_ovf, r.rw, r.uds_n, r.lds_n, r.fc};
      m_ovf  = 1'b0;
    end else begin
      m_sig[7] = 1'b0;
      m_sig[6] = m_ovf;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".addr"}, ADDR_OUT, m_addr);
    check({tag, ".data"}, DATA_OUT, m_data);
    check({tag, ".sig"}, SIGNAL_OUT, m_sig);
  endtask

  task automatic drive_fields(input rec_t r);
    ADDR_IN  = r.addr;
    DATA_IN  = r.data;
    RW_IN    = r.rw;
    UDS_N_IN = r.uds_n;
    LDS_N_IN = r.lds_n;
    FC_IN    = r.fc;
  endtask

  task automatic bus_cycle(input rec_t r, input int hold);
    drive_fields(r);
    AS_N_IN = 1'b0;
    tick(1);
    DTACK_N_IN = 1'b0;
    tick(hold);
    DTACK_N_IN = 1'b1;
    AS_N_IN    = 1'b1;
    tick(SS + 3);
    model_push(r);
    check("count_after_push", COUNT_OUT, m_q.size());
  endtask

  task automatic spi_window(input int len);
    SPISS_IN = 1'b1;
    tick(SS + 2);
    model_pop();
    check_outputs("win_early");
    tick(len - (SS + 2));
    check_outputs("win_late");
    SPISS_IN = 1'b0;
    tick(SS + 2);
    check_outputs("win_after");
    check("count_after_pop", COUNT_OUT, m_q.size());
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.addr  = 24'($urandom);
    r.data  = 16'($urandom);
    r.rw    = 1'($urandom);
    r.uds_n = 1'($urandom);
    r.lds_n = 1'($urandom);
    r.fc    = 3'($urandom);
    return r;
  endfunction

  initial begin
    rec_t r;
    RESET_IN   = 1'b0;
    AS_N_IN    = 1'b1;
    DTACK_N_IN = 1'b1;
    SPISS_IN   = 1'b0;
    drive_fields('0);
    model_reset();
    tick(3);
    check("reset_addr", ADDR_OUT, 24'h0);
    check("reset_data", DATA_OUT, 16'h0);
    check("reset_sig", SIGNAL_OUT, 8'h00);
    check("reset_count", COUNT_OUT, 3'd0);
    RESET_IN = 1'b1;
    tick(2);

    // Empty windows straight after reset
    spi_window(SS + 5);
    check("empty1_sig", SIGNAL_OUT, 8'h00);
    spi_window(SS + 5);
    check("empty2_addr", ADDR_OUT, 24'h0);

    // Single read cycle
    r = '{addr: 24'h00FC04, data: 16'h4E71, rw: 1'b1, uds_n: 1'b0, lds_n: 1'b0, fc: 3'd6};
    bus_cycle(r, 5);
    check("read_count1", COUNT_OUT, 3'd1);
    spi_window(SS + 6);
    check("read_addr", ADDR_OUT, 24'h00FC04);
    check("read_data", DATA_OUT, 16'h4E71);
    check("read_sig", SIGNAL_OUT, 8'hA6);
    check("read_count0", COUNT_OUT, 3'd0);

    // Six writes into a four-deep FIFO
    for (int i = 0; i < 6; i++) begin
      r = '{addr: 24'h1000 + 24'(2 * i), data: 16'($urandom), rw: 1'b0,
            uds_n: 1'b0, lds_n: 1'b0, fc: 3'd5};
      bus_cycle(r, 3);
    end
    check("ovf_full_count", COUNT_OUT, 3'd4);
    for (int i = 0; i < 5; i++) begin
      spi_window(SS + 4);
      if (i == 0) check("ovf_w1_valid_ovr", SIGNAL_OUT[7:6], 2'b11);
      if (i > 0 && i < 4) check("ovf_w_addr", ADDR_OUT, 24'h1000 + 24'(2 * i));
      if (i == 4) check("ovf_w5_valid", SIGNAL_OUT[7], 1'b0);
    end

    // Full FIFO with push and pop landing on the same edge
    for (int i = 0; i < DEPTH; i++) bus_cycle(rand_rec(), 2);
    r = rand_rec();
    drive_fields(r);
    AS_N_IN = 1'b0;
    tick(1);
    DTACK_N_IN = 1'b0;
    SPISS_IN   = 1'b1;
    tick(SS + 2);
    model_pop();
    model_push(r);
    check_outputs("simul");
    check("simul_ovr", SIGNAL_OUT[6], 1'b0);
    check("simul_count", COUNT_OUT, 3'd4);
    DTACK_N_IN = 1'b1;
    AS_N_IN    = 1'b1;
    tick(3);
    SPISS_IN = 1'b0;
    tick(SS + 2);
    for (int i = 0; i < DEPTH + 1; i++) spi_window(SS + 3);

    // Long DTACK gives exactly one push
    bus_cycle(rand_rec(), 40);
    check("long_dtack_count", COUNT_OUT, 3'd1);
    spi_window(SS + 3);

    // Asynchronous reset in the middle of a window
    for (int i = 0; i < 3; i++) bus_cycle(rand_rec(), 2);
    SPISS_IN = 1'b1;
    tick(SS + 2);
    model_pop();
    check_outputs("pre_reset");
    #2 RESET_IN = 1'b0;
    #1;
    check("mid_reset_addr", ADDR_OUT, 24'h0);
    check("mid_reset_data", DATA_OUT, 16'h0);
    check("mid_reset_sig", SIGNAL_OUT, 8'h00);
    check("mid_reset_count", COUNT_OUT, 3'd0);
    SPISS_IN = 1'b0;
    tick(2);
    RESET_IN = 1'b1;
    model_reset();
    tick(2);
    spi_window(SS + 4);
    check("post_reset_valid", SIGNAL_OUT[7], 1'b0);

    // Random mix of bus cycles and windows
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) bus_cycle(rand_rec(), $urandom_range(1, 8));
      else spi_window($urandom_range(SS + 3, SS + 8));
    end
    for (int i = 0; i < DEPTH + 1; i++) spi_window(SS + 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
